// File: rtl/riscv_fetch_q_pkg.sv
// Shared constants for the RV32I fetch stage: NOP encoding, state encodings, default reset PC.
package riscv_fetch_q_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/riscv_fetch_q_if.sv
// Fetch-stage bus bundle: imem request/response, execute redirect, decode handshake.
// Signal names are seen from the fetch stage (master) side.
interface riscv_fetch_q_if #(
    parameter int XLEN = 32
);
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_gnt;
    logic            i_imem_rvalid;
    logic [31:0]     i_imem_rdata;
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_pc;
    logic            i_stall_d;
    logic            o_if_valid;
    logic [31:0]     o_if_instr;
    logic [XLEN-1:0] o_if_pc;
    logic [XLEN-1:0] o_if_pc4;

    modport master (
        output o_imem_req, o_imem_addr, o_if_valid, o_if_instr, o_if_pc, o_if_pc4,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_redirect, i_redirect_pc, i_stall_d
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_if_valid, o_if_instr, o_if_pc, o_if_pc4,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_redirect, i_redirect_pc, i_stall_d
    );
endinterface

// File: rtl/riscv_fetch_fifo.sv
// Synchronous FIFO of {pc, instr} pairs with clear; head is read straight from storage.
module riscv_fetch_fifo #(
    parameter int XLEN   = 32,
    parameter int QDEPTH = 4,
    localparam int AW    = $clog2(QDEPTH),
    localparam int CW    = AW + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_push,
    input  logic [XLEN-1:0] i_push_pc,
    input  logic [31:0]     i_push_instr,
    input  logic            i_pop,
    input  logic            i_clear,
    output logic [CW-1:0]   o_count,
    output logic [XLEN-1:0] o_head_pc,
    output logic [31:0]     o_head_instr
);

    logic [QDEPTH-1:0][XLEN-1:0] r_pc_mem;
    logic [QDEPTH-1:0][31:0]     r_instr_mem;
    logic [AW-1:0]               r_wr;
    logic [AW-1:0]               r_rd;
    logic [CW-1:0]               r_count;
    logic                        w_pop;

    assign w_pop        = i_pop && (r_count != '0);
    assign o_count      = r_count;
    assign o_head_pc    = r_pc_mem[r_rd];
    assign o_head_instr = r_instr_mem[r_rd];

    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) begin
            r_pc_mem[r_wr]    <= i_push_pc;
            r_instr_mem[r_wr] <= i_push_instr;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The credit limit upstream keeps a push on a full FIFO always paired with a pop.
    assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && !i_clear && !w_pop && (r_count == CW'(QDEPTH))));

endmodule

// File: rtl/riscv_fetch_q.sv
// RV32I instruction-fetch stage: credit-limited in-order imem requests, response FIFO,
// redirect flush with stale-response discard. Optional perf counters: RISCV_FETCH_PERF_EN.
module riscv_fetch_q
    import riscv_fetch_q_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int              QDEPTH   = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    riscv_fetch_q_if.master bus
`ifdef RISCV_FETCH_PERF_EN
    ,
    output logic [31:0]     o_perf_fetch_cnt,
    output logic [31:0]     o_perf_bubble_cnt
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [XLEN-1:0] r_last_pc;
    logic [CW-1:0]   r_out;
    logic [CW-1:0]   r_stale;

    logic [CW-1:0]   w_occ;
    logic [CW-1:0]   w_out_nxt;
    logic [CW-1:0]   w_stale_nxt;
    logic [XLEN-1:0] w_tgt;
    logic [XLEN-1:0] w_head_pc;
    logic [31:0]     w_head_instr;
    logic            w_live;
    logic            w_req;
    logic            w_gnt;
    logic            w_rsp;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;

    assign w_live  = (r_state != ST_RESET);
    assign w_tgt   = bus.i_redirect_pc & ~XLEN'(3);
    assign w_valid = (w_occ != '0);
    // Occupancy plus in-flight requests never exceeds QDEPTH, so every response has a slot.
    assign w_req   = w_live && !bus.i_redirect &&
                     (({1'b0, w_occ} + {1'b0, r_out}) < (CW + 1)'(QDEPTH));
    assign w_gnt   = w_req && bus.i_imem_gnt;
    assign w_rsp   = bus.i_imem_rvalid && w_live && (r_out != '0);
    assign w_drop  = w_rsp && ((r_stale != '0) || bus.i_redirect);
    assign w_push  = w_rsp && !w_drop;
    assign w_pop   = w_valid && !bus.i_stall_d && !bus.i_redirect;

    always_comb begin
        w_out_nxt = r_out;
        if (w_gnt && !w_rsp)      w_out_nxt = r_out + CW'(1);
        else if (!w_gnt && w_rsp) w_out_nxt = r_out - CW'(1);
    end

    always_comb begin
        w_stale_nxt = r_stale;
        if (bus.i_redirect)                w_stale_nxt = w_out_nxt;
        else if (w_rsp && r_stale != '0)   w_stale_nxt = r_stale - CW'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_RESET;
            r_pc      <= RESET_PC;
            r_rsp_pc  <= RESET_PC;
            r_last_pc <= RESET_PC;
            r_out     <= '0;
            r_stale   <= '0;
        end else begin
            r_out   <= w_out_nxt;
            r_stale <= w_stale_nxt;
            if (w_valid) r_last_pc <= w_head_pc;
            if (bus.i_redirect) begin
                r_pc     <= w_tgt;
                r_rsp_pc <= w_tgt;
            end else begin
                if (w_gnt)  r_pc     <= r_pc + XLEN'(4);
                if (w_push) r_rsp_pc <= r_rsp_pc + XLEN'(4);
            end
            case (r_state)
                ST_RESET:   r_state <= ST_FETCH;
                ST_FETCH:   if (bus.i_redirect && w_stale_nxt != '0) r_state <= ST_DISCARD;
                ST_DISCARD: if (!bus.i_redirect && w_stale_nxt == '0) r_state <= ST_FETCH;
                default:    r_state <= ST_RESET;
            endcase
        end
    end

    riscv_fetch_fifo #(
        .XLEN   (XLEN),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (w_push),
        .i_push_pc    (r_rsp_pc),
        .i_push_instr (bus.i_imem_rdata),
        .i_pop        (w_pop),
        .i_clear      (bus.i_redirect),
        .o_count      (w_occ),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr)
    );

    assign bus.o_imem_req  = w_req;
    assign bus.o_imem_addr = r_pc;
    assign bus.o_if_valid  = w_valid;
    assign bus.o_if_instr  = w_valid ? w_head_instr : NOP_INSTR;
    assign bus.o_if_pc     = w_valid ? w_head_pc : r_last_pc;
    assign bus.o_if_pc4    = bus.o_if_pc + XLEN'(4);

`ifdef RISCV_FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_bubble;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf_fetch  <= '0;
            r_perf_bubble <= '0;
        end else begin
            if (w_pop) r_perf_fetch <= r_perf_fetch + 32'd1;
            if (w_live && !w_valid && !bus.i_stall_d) r_perf_bubble <= r_perf_bubble + 32'd1;
        end
    end

    assign o_perf_fetch_cnt  = r_perf_fetch;
    assign o_perf_bubble_cnt = r_perf_bubble;
`endif

endmodule

// File: tb/tb_riscv_fetch_q.sv
// Bench for riscv_fetch_q: bench-side memory with variable latency, queue-based program-order
// model, directed latency/stall/redirect/reset steps followed by a randomized phase.
`timescale 1ns/1ps
module tb_riscv_fetch_q;
    import riscv_fetch_q_pkg::*;

    localparam int          QD  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } inf_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_fetch_q_if #(.XLEN(32)) bus ();

`ifdef RISCV_FETCH_PERF_EN
    logic [31:0] perf_f;
    logic [31:0] perf_b;
`endif

    riscv_fetch_q #(
        .XLEN     (32),
        .RESET_PC (RPC),
        .QDEPTH   (QD)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
`ifdef RISCV_FETCH_PERF_EN
        ,
        .o_perf_fetch_cnt  (perf_f),
        .o_perf_bubble_cnt (perf_b)
`endif
    );

    int          checks;
    int          errors;
    int          cyc;
    int          lat;
    int          rel;
    int          first_valid;
    bit          junk_rv;
    bit          m_live;
    logic [31:0] m_fetch_pc;
    logic [31:0] m_fcnt;
    logic [31:0] m_bcnt;
    logic [31:0] pc_hist [8];
    mreq_t       mem_q [$];
    inf_t        m_inf [$];
    logic [31:0] m_q   [$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h0000_0093 + (a << 5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(bus.o_imem_req), 32'd0);
        chk({tag, "_addr"},  bus.o_imem_addr, RPC);
        chk({tag, "_valid"}, 32'(bus.o_if_valid), 32'd0);
        chk({tag, "_instr"}, bus.o_if_instr, NOP_INSTR);
        chk({tag, "_pc"},    bus.o_if_pc, RPC);
        chk({tag, "_pc4"},   bus.o_if_pc4, RPC + 32'd4);
    endtask

    // One clock: check outputs at the falling edge, advance model + memory, drive next response.
    task automatic cycle();
        bit    exp_req;
        bit    popv;
        mreq_t mr;
        inf_t  ie;
        @(negedge clk);
        if (rst) begin
            m_q.delete();
            m_inf.delete();
            mem_q.delete();
            m_live     = 1'b0;
            m_fetch_pc = RPC;
            m_fcnt     = '0;
            m_bcnt     = '0;
            rel        = 0;
            for (int i = 0; i < 8; i++) pc_hist[i] = 32'hDEAD_BEEF;
        end else begin
            exp_req = m_live && !bus.i_redirect && ((m_q.size() + m_inf.size()) < QD);
            chk("req", 32'(bus.o_imem_req), 32'(exp_req));
            if (exp_req) chk("addr", bus.o_imem_addr, m_fetch_pc);
            chk("valid", 32'(bus.o_if_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("pc",    bus.o_if_pc,    m_q[0]);
                chk("instr", bus.o_if_instr, instr_of(m_q[0]));
                chk("pc4",   bus.o_if_pc4,   m_q[0] + 32'd4);
            end else begin
                chk("nop", bus.o_if_instr, NOP_INSTR);
            end
            if (first_valid < 0 && bus.o_if_valid) first_valid = rel;
            if (rel < 8 && bus.o_if_valid) pc_hist[rel] = bus.o_if_pc;

            if (bus.o_imem_req && bus.i_imem_gnt) begin
                mr.addr = bus.o_imem_addr;
                mr.due  = cyc + lat;
                mem_q.push_back(mr);
            end
            if (bus.i_imem_rvalid && mem_q.size() != 0) mem_q.delete(0);

            popv = (m_q.size() != 0) && !bus.i_stall_d && !bus.i_redirect;
            if (m_live && m_q.size() == 0 && !bus.i_stall_d) m_bcnt++;
            if (popv) begin
                m_q.delete(0);
                m_fcnt++;
            end
            if (bus.i_imem_rvalid && m_live && m_inf.size() != 0) begin
                if (!m_inf[0].stale && !bus.i_redirect) m_q.push_back(m_inf[0].pc);
                m_inf.delete(0);
            end
            if (exp_req && bus.i_imem_gnt) begin
                ie.pc    = m_fetch_pc;
                ie.stale = 1'b0;
                m_inf.push_back(ie);
                m_fetch_pc += 32'd4;
            end
            if (bus.i_redirect) begin
                m_q.delete();
                foreach (m_inf[i]) m_inf[i].stale = 1'b1;
                m_fetch_pc = bus.i_redirect_pc & ~32'h3;
            end
            m_live = 1'b1;
            rel++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            bus.i_imem_rvalid = junk_rv;
            bus.i_imem_rdata  = $urandom;
        end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            bus.i_imem_rvalid = 1'b1;
            bus.i_imem_rdata  = instr_of(mem_q[0].addr);
        end else begin
            bus.i_imem_rvalid = 1'b0;
            bus.i_imem_rdata  = $urandom;
        end
    endtask

    task automatic wait_valid(input int budget);
        for (int k = 0; k < budget && !bus.o_if_valid; k++) cycle();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; lat = 1; rel = 0; first_valid = -1; junk_rv = 1'b0;
        m_live = 1'b0; m_fetch_pc = RPC; m_fcnt = '0; m_bcnt = '0;
        bus.i_imem_gnt = 1'b0; bus.i_imem_rvalid = 1'b0; bus.i_imem_rdata = '0;
        bus.i_redirect = 1'b0; bus.i_redirect_pc = '0; bus.i_stall_d = 1'b0;

        // Reset values, then release with a 1-cycle memory.
        #2;
        chk_reset_outputs("rst0");
        repeat (3) cycle();
        rst = 1'b0; bus.i_imem_rvalid = 1'b0; bus.i_imem_gnt = 1'b1; first_valid = -1;
        repeat (8) cycle();
        chk("lat_first_valid", 32'(first_valid), 32'd3);
        chk("lat_pc_c3", pc_hist[3], 32'h0);
        chk("lat_pc_c4", pc_hist[4], 32'h4);
        chk("lat_pc_c5", pc_hist[5], 32'h8);

        // Decode stall: credit runs out, nothing lost after release.
        bus.i_stall_d = 1'b1;
        repeat (6) cycle();
        #1;
        chk("stall_req_off", 32'(bus.o_imem_req), 32'd0);
        chk("stall_valid",   32'(bus.o_if_valid), 32'd1);
        bus.i_stall_d = 1'b0;
        repeat (10) cycle();

        // Redirect with two 3-cycle requests in flight.
        bus.i_imem_gnt = 1'b0;
        repeat (10) cycle();
        lat = 3; bus.i_imem_gnt = 1'b1;
        repeat (2) cycle();
        bus.i_imem_gnt = 1'b0;
        bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h0000_0100;
        cycle();
        bus.i_redirect = 1'b0;
        #1;
        chk("redir_valid_n1", 32'(bus.o_if_valid), 32'd0);
        chk("redir_req_n1",   32'(bus.o_imem_req), 32'd1);
        chk("redir_addr_n1",  bus.o_imem_addr, 32'h0000_0100);
        lat = 1; bus.i_imem_gnt = 1'b1;
        wait_valid(30);
        chk("redir_first_valid", 32'(bus.o_if_valid), 32'd1);
        chk("redir_first_pc",    bus.o_if_pc, 32'h0000_0100);

        // Redirect in a cycle that also carries a response and a grant.
        repeat (6) cycle();
        bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h0000_0200;
        cycle();
        bus.i_redirect = 1'b0;
        wait_valid(30);
        chk("coinc_first_pc", bus.o_if_pc, 32'h0000_0200);

        // Unaligned target and address wrap.
        repeat (3) cycle();
        bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h0000_0102;
        cycle();
        bus.i_redirect = 1'b0;
        #1;
        chk("align_addr", bus.o_imem_addr, 32'h0000_0100);
        wait_valid(30);
        chk("align_pc", bus.o_if_pc, 32'h0000_0100);
        bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'hFFFF_FFFC;
        cycle();
        bus.i_redirect = 1'b0;
        #1;
        chk("wrap_addr0", bus.o_imem_addr, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_addr1", bus.o_imem_addr, 32'h0000_0000);
        wait_valid(30);
        chk("wrap_pc",  bus.o_if_pc,  32'hFFFF_FFFC);
        chk("wrap_pc4", bus.o_if_pc4, 32'h0000_0000);
        cycle();
        chk("wrap_next_pc", bus.o_if_pc, 32'h0000_0000);

        // Asynchronous reset with three requests in flight.
        bus.i_imem_gnt = 1'b0;
        repeat (10) cycle();
        lat = 3; bus.i_imem_gnt = 1'b1;
        repeat (3) cycle();
        rst = 1'b1; junk_rv = 1'b1; bus.i_imem_gnt = 1'b0;
        #1;
        chk_reset_outputs("arst");
`ifdef RISCV_FETCH_PERF_EN
        chk("arst_perf_fetch",  perf_f, 32'd0);
        chk("arst_perf_bubble", perf_b, 32'd0);
`endif
        repeat (3) cycle();
        rst = 1'b0; junk_rv = 1'b0; bus.i_imem_rvalid = 1'b0; lat = 1; bus.i_imem_gnt = 1'b1;
        first_valid = -1;
        repeat (6) cycle();
        chk("restart_first_valid", 32'(first_valid), 32'd3);
        chk("restart_pc", pc_hist[3], RPC);

        // Randomized traffic: grant gaps, stalls, variable latency, occasional redirects.
        for (int n = 0; n < 1500; n++) begin
            bus.i_imem_gnt    = ($urandom_range(0, 3) != 0);
            bus.i_stall_d     = ($urandom_range(0, 3) == 0);
            bus.i_redirect    = ($urandom_range(0, 39) == 0);
            bus.i_redirect_pc = $urandom;
            lat               = $urandom_range(1, 4);
            cycle();
        end
        bus.i_redirect = 1'b0; bus.i_stall_d = 1'b0;
        cycle();
`ifdef RISCV_FETCH_PERF_EN
        #1;
        chk("perf_fetch",  perf_f, m_fcnt);
        chk("perf_bubble", perf_b, m_bcnt);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
